// File: rtl/ecdsa_pkg.sv
// Shared types and default widths for the ECDSA signing front end.
package ecdsa_pkg;

    localparam int DEF_KEY_W  = 256;
    localparam int DEF_HASH_W = 256;
    localparam int DEF_SIG_W  = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_BAD_SHARD = 2'd1,
        ERR_TIMEOUT   = 2'd2
    } err_e;

    function automatic int shard_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ecdsa_key_select.sv
// Picks the signing key for a request: the full private key, or one shard
// slice in partial mode, flagging shard indices beyond the populated range.
module ecdsa_key_select
    import ecdsa_pkg::*;
#(
    parameter int KEY_W      = DEF_KEY_W,
    parameter int NUM_SHARDS = 4,
    parameter int SH_W       = shard_idx_w(NUM_SHARDS)
) (
    input  logic                        partial,
    input  logic [SH_W-1:0]             shard,
    input  logic [KEY_W-1:0]            private_key,
    input  logic [NUM_SHARDS*KEY_W-1:0] partial_keys,
    output logic [KEY_W-1:0]            key,
    output logic                        shard_bad
);

    // Loop compare keeps the slice index in range even when SH_W can encode
    // more values than there are shards.
    always_comb begin
        key       = '0;
        shard_bad = partial;
        if (!partial) begin
            key = private_key;
        end else begin
            for (int unsigned i = 0; i < NUM_SHARDS; i++) begin
                if (shard == SH_W'(i)) begin
                    key       = partial_keys[i*KEY_W +: KEY_W];
                    shard_bad = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ecdsa_sign_dispatch.sv
// Front end for the ECDSA signer: accepts one request, drives the engine through
// start/done with a timeout, returns the response, then zeroizes held secrets.
module ecdsa_sign_dispatch
    import ecdsa_pkg::*;
#(
    parameter int  KEY_W       = DEF_KEY_W,
    parameter int  HASH_W      = DEF_HASH_W,
    parameter int  SIG_W       = DEF_SIG_W,
    parameter int  NUM_SHARDS  = 4,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int SH_W        = shard_idx_w(NUM_SHARDS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_partial,
    input  logic [SH_W-1:0]             req_shard,
    input  logic [HASH_W-1:0]           req_hash,
    input  logic [KEY_W-1:0]            private_key,
    input  logic [NUM_SHARDS*KEY_W-1:0] partial_keys,
    output logic                        eng_start,
    output logic                        eng_abort,
    output logic [KEY_W-1:0]            eng_key,
    output logic [HASH_W-1:0]           eng_hash,
    input  logic                        eng_done,
    input  logic [SIG_W-1:0]            eng_sig,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [SIG_W-1:0]            rsp_sig,
    output logic                        rsp_partial,
    output logic [SH_W-1:0]             rsp_shard,
    output logic [1:0]                  rsp_err,
    output logic [15:0]                 err_count
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic               eng_start_q, eng_start_d;
    logic               eng_abort_q, eng_abort_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [SIG_W-1:0]   rsp_sig_q, rsp_sig_d;
    logic               rsp_partial_q, rsp_partial_d;
    logic [SH_W-1:0]    rsp_shard_q, rsp_shard_d;
    err_e               rsp_err_q, rsp_err_d;
    logic [15:0]        err_count_q, err_count_d;

    logic [KEY_W-1:0]   sel_key;
    logic               sel_bad;

    ecdsa_key_select #(
        .KEY_W      (KEY_W),
        .NUM_SHARDS (NUM_SHARDS),
        .SH_W       (SH_W)
    ) u_key_select (
        .partial      (req_partial),
        .shard        (req_shard),
        .private_key  (private_key),
        .partial_keys (partial_keys),
        .key          (sel_key),
        .shard_bad    (sel_bad)
    );

    // The timer counts cycles since eng_start: 0 in START, so the WAIT cycle
    // holding TIMEOUT_CYC-1 is the last one in which eng_done is accepted.
    // The abort pulse cycle stays in WAIT and ignores eng_done.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        key_d         = key_q;
        hash_d        = hash_q;
        eng_start_d   = 1'b0;
        eng_abort_d   = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_sig_d     = rsp_sig_q;
        rsp_partial_d = rsp_partial_q;
        rsp_shard_d   = rsp_shard_q;
        rsp_err_d     = rsp_err_q;
        err_count_d   = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    hash_d        = req_hash;
                    rsp_partial_d = req_partial;
                    rsp_shard_d   = req_partial ? req_shard : '0;
                    rsp_sig_d     = '0;
                    if (sel_bad) begin
                        rsp_err_d   = ERR_BAD_SHARD;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        key_d       = sel_key;
                        rsp_err_d   = ERR_OK;
                        eng_start_d = 1'b1;
                        timer_d     = '0;
                        state_d     = S_START;
                    end
                end
            end
            S_START: begin
                timer_d = timer_q + TMR_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_abort_q) begin
                    key_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (eng_done) begin
                    key_d       = '0;
                    rsp_sig_d   = eng_sig;
                    rsp_err_d   = ERR_OK;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    eng_abort_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_sig_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (rsp_err_q != ERR_OK && err_count_q != '1) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    key_d         = '0;
                    hash_d        = '0;
                    rsp_sig_d     = '0;
                    rsp_valid_d   = 1'b0;
                    rsp_partial_d = 1'b0;
                    rsp_shard_d   = '0;
                    rsp_err_d     = ERR_OK;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            key_q         <= '0;
            hash_q        <= '0;
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_sig_q     <= '0;
            rsp_partial_q <= 1'b0;
            rsp_shard_q   <= '0;
            rsp_err_q     <= ERR_OK;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            key_q         <= key_d;
            hash_q        <= hash_d;
            eng_start_q   <= eng_start_d;
            eng_abort_q   <= eng_abort_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_sig_q     <= rsp_sig_d;
            rsp_partial_q <= rsp_partial_d;
            rsp_shard_q   <= rsp_shard_d;
            rsp_err_q     <= rsp_err_d;
            err_count_q   <= err_count_d;
        end
    end

    // Gated by reset_n so every output reads 0 while reset is held.
    assign req_ready   = (state_q == S_IDLE) && reset_n;
    assign eng_start   = eng_start_q;
    assign eng_abort   = eng_abort_q;
    assign eng_key     = key_q;
    assign eng_hash    = hash_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_sig     = rsp_sig_q;
    assign rsp_partial = rsp_partial_q;
    assign rsp_shard   = rsp_shard_q;
    assign rsp_err     = rsp_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_ecdsa_sign_dispatch.sv
// Randomized self-checking bench for ecdsa_sign_dispatch with a job-level
// reference model (expected latency, error code, signature and key per request).
module tb_ecdsa_sign_dispatch;

    localparam int KEY_W  = 256;
    localparam int HASH_W = 256;
    localparam int SIG_W  = 512;
    localparam int NSH    = 3;
    localparam int TO     = 16;
    localparam int SH_W   = 2;

    logic                   clk;
    logic                   reset_n;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_partial;
    logic [SH_W-1:0]        req_shard;
    logic [HASH_W-1:0]      req_hash;
    logic [KEY_W-1:0]       private_key;
    logic [NSH*KEY_W-1:0]   partial_keys;
    logic                   eng_start;
    logic                   eng_abort;
    logic [KEY_W-1:0]       eng_key;
    logic [HASH_W-1:0]      eng_hash;
    logic                   eng_done;
    logic [SIG_W-1:0]       eng_sig;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SIG_W-1:0]       rsp_sig;
    logic                   rsp_partial;
    logic [SH_W-1:0]        rsp_shard;
    logic [1:0]             rsp_err;
    logic [15:0]            err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err_count = 0;

    ecdsa_sign_dispatch #(
        .KEY_W       (KEY_W),
        .HASH_W      (HASH_W),
        .SIG_W       (SIG_W),
        .NUM_SHARDS  (NSH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_partial  (req_partial),
        .req_shard    (req_shard),
        .req_hash     (req_hash),
        .private_key  (private_key),
        .partial_keys (partial_keys),
        .eng_start    (eng_start),
        .eng_abort    (eng_abort),
        .eng_key      (eng_key),
        .eng_hash     (eng_hash),
        .eng_done     (eng_done),
        .eng_sig      (eng_sig),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sig      (rsp_sig),
        .rsp_partial  (rsp_partial),
        .rsp_shard    (rsp_shard),
        .rsp_err      (rsp_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Job-level reference: outcome of one request given when the engine answers.
    // done_cyc is the cycle (request accept = cycle 0) in which eng_done is driven.
    task automatic model(input logic partial, input int shard, input int done_cyc,
                         input logic [SIG_W-1:0] sig,
                         output logic [1:0] e_err, output int e_rsp, output int e_start,
                         output int e_abort, output logic [SIG_W-1:0] e_sig,
                         output logic [KEY_W-1:0] e_key);
        if (partial && shard >= NSH) begin
            e_err = 2'd1; e_rsp = 1; e_start = 0; e_abort = 0; e_sig = '0; e_key = '0;
        end else begin
            e_key   = partial ? partial_keys[shard*KEY_W +: KEY_W] : private_key;
            e_start = 1;
            if (done_cyc >= 2 && done_cyc <= TO) begin
                e_err = 2'd0; e_rsp = done_cyc + 1; e_abort = 0; e_sig = sig;
            end else begin
                e_err = 2'd2; e_rsp = TO + 2; e_abort = 1; e_sig = '0;
            end
        end
    endtask

    task automatic run_job(input string name, input logic partial, input int shard,
                           input logic [HASH_W-1:0] hash, input int done_cyc,
                           input logic [SIG_W-1:0] sig, input int hold);
        logic [1:0]       e_err;
        int               e_rsp, e_start, e_abort;
        logic [SIG_W-1:0] e_sig;
        logic [KEY_W-1:0] e_key;
        int rsp_cyc = -1, starts = 0, aborts = 0, abort_cyc = -1;
        int key_bad = 0, ready_bad = 0, stable_bad = 0;

        model(partial, shard, done_cyc, sig, e_err, e_rsp, e_start, e_abort, e_sig, e_key);

        req_valid   = 1'b1;
        req_partial = partial;
        req_shard   = SH_W'(shard);
        req_hash    = hash;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready_idle got %b exp 1", name, req_ready);
        end
        @(posedge clk); #1;
        // Change live inputs so only latched values can satisfy the checks.
        req_valid   = 1'b0;
        req_hash    = rnd512();
        req_shard   = SH_W'($urandom);
        private_key = rnd512();

        for (int c = 1; c <= TO + 8; c++) begin
            if (eng_start) starts++;
            if (eng_abort) begin aborts++; abort_cyc = c; end
            if (rsp_valid) begin rsp_cyc = c; break; end
            if (eng_key !== e_key || eng_hash !== hash) key_bad++;
            if (req_ready !== 1'b0) ready_bad++;
            eng_done = (c == done_cyc);
            eng_sig  = (c == done_cyc) ? sig : rnd512();
            @(posedge clk); #1;
            eng_done = 1'b0;
        end

        n_checks++;
        if (rsp_cyc !== e_rsp) begin
            n_fail++; $display("FAIL %s rsp_valid_cycle got %0d exp %0d", name, rsp_cyc, e_rsp);
        end
        n_checks++;
        if (starts !== e_start) begin
            n_fail++; $display("FAIL %s eng_start_count got %0d exp %0d", name, starts, e_start);
        end
        n_checks++;
        if (aborts !== e_abort || abort_cyc !== (e_abort != 0 ? TO + 1 : -1)) begin
            n_fail++; $display("FAIL %s eng_abort got count %0d cycle %0d exp count %0d",
                               name, aborts, abort_cyc, e_abort);
        end
        n_checks++;
        if (key_bad !== 0 || ready_bad !== 0) begin
            n_fail++; $display("FAIL %s busy_cycles key/hash bad %0d ready bad %0d exp 0/0",
                               name, key_bad, ready_bad);
        end
        n_checks++;
        if (rsp_err !== e_err) begin
            n_fail++; $display("FAIL %s rsp_err got %0d exp %0d", name, rsp_err, e_err);
        end
        n_checks++;
        if (rsp_sig !== e_sig) begin
            n_fail++; $display("FAIL %s rsp_sig got %h exp %h", name, rsp_sig, e_sig);
        end
        n_checks++;
        if (rsp_partial !== partial || rsp_shard !== (partial ? SH_W'(shard) : SH_W'(0))) begin
            n_fail++; $display("FAIL %s rsp_echo got partial %b shard %0d exp %b %0d",
                               name, rsp_partial, rsp_shard, partial, partial ? shard : 0);
        end
        n_checks++;
        if (eng_key !== '0) begin
            n_fail++; $display("FAIL %s eng_key_in_resp got %h exp 0", name, eng_key);
        end

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            eng_done  = 1'($urandom);
            eng_sig   = rnd512();
            @(posedge clk); #1;
            eng_done  = 1'b0;
            if (rsp_valid !== 1'b1 || rsp_sig !== e_sig || rsp_err !== e_err ||
                req_ready !== 1'b0) stable_bad++;
        end
        n_checks++;
        if (stable_bad !== 0) begin
            n_fail++; $display("FAIL %s hold_stable got %0d bad cycles exp 0", name, stable_bad);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (e_err != 2'd0 && exp_err_count < 16'hFFFF) exp_err_count++;

        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after_handshake got valid %b ready %b exp 0 1",
                               name, rsp_valid, req_ready);
        end
        n_checks++;
        if (rsp_sig !== '0 || eng_key !== '0 || eng_hash !== '0 || dut.key_q !== '0) begin
            n_fail++; $display("FAIL %s zeroize got sig %h key %h exp 0", name, rsp_sig, dut.key_q);
        end
        n_checks++;
        if (err_count !== 16'(exp_err_count)) begin
            n_fail++; $display("FAIL %s err_count got %0d exp %0d", name, err_count, exp_err_count);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, eng_start, eng_abort, rsp_valid, rsp_partial} !== 5'b0 ||
            eng_key !== '0 || eng_hash !== '0 || rsp_sig !== '0 || rsp_shard !== '0 ||
            rsp_err !== 2'd0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_outputs got ready %b start %b valid %b cnt %0d exp all 0",
                               req_ready, eng_start, rsp_valid, err_count);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_full();
        logic [HASH_W-1:0] h;
        h = {32{8'hA5}};
        run_job("full_a5", 1'b0, 0, h, 11, 512'h1234, 0);
    endtask

    task automatic test_partial();
        run_job("partial_s2", 1'b1, 2, rnd512(), 5, rnd512(), 1);
        run_job("partial_s0", 1'b1, 0, rnd512(), 2, rnd512(), 0);
    endtask

    task automatic test_bad_shard();
        run_job("bad_shard3", 1'b1, 3, rnd512(), 4, rnd512(), 0);
    endtask

    task automatic test_timeout();
        run_job("timeout_never", 1'b0, 0, rnd512(), -1, rnd512(), 0);
        run_job("done_at_timeout", 1'b0, 0, rnd512(), TO, rnd512(), 0);
        run_job("done_in_abort_cyc", 1'b1, 1, rnd512(), TO + 1, rnd512(), 0);
        run_job("done_in_start", 1'b0, 0, rnd512(), 1, rnd512(), 0);
    endtask

    task automatic test_backpressure();
        run_job("hold20", 1'b1, 1, rnd512(), 7, rnd512(), 20);
    endtask

    task automatic test_reset_midjob();
        int aborts = 0;
        req_valid   = 1'b1;
        req_partial = 1'b0;
        req_hash    = rnd512();
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, eng_start, eng_abort, rsp_valid} !== 4'b0 || eng_key !== '0 ||
            eng_hash !== '0 || rsp_sig !== '0 || rsp_err !== 2'd0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_midjob_outputs got ready %b key %h cnt %0d exp all 0",
                               req_ready, eng_key, err_count);
        end
        exp_err_count = 0;
        repeat (2) begin @(posedge clk); #1; if (eng_abort) aborts++; end
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < TO + 4; c++) begin
            @(posedge clk); #1;
            if (eng_abort || eng_start || rsp_valid) aborts++;
        end
        n_checks++;
        if (aborts !== 0) begin
            n_fail++; $display("FAIL reset_midjob_silent got %0d activity cycles exp 0", aborts);
        end
        run_job("after_reset", 1'b0, 0, rnd512(), 3, rnd512(), 0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 14; j++) begin
            logic p;
            int   s, d, r;
            p = 1'($urandom);
            s = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            d = (r == 0) ? -1 : $urandom_range(1, TO + 2);
            run_job($sformatf("rand%0d", j), p, s, rnd512(), d, rnd512(), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset_n      = 1'b1;
        req_valid    = 1'b0;
        req_partial  = 1'b0;
        req_shard    = '0;
        req_hash     = '0;
        eng_done     = 1'b0;
        eng_sig      = '0;
        rsp_ready    = 1'b0;
        private_key  = rnd512();
        for (int i = 0; i < NSH; i++) partial_keys[i*KEY_W +: KEY_W] = rnd512();

        test_reset();
        test_full();
        test_partial();
        test_bad_shard();
        test_timeout();
        test_backpressure();
        test_reset_midjob();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
